// File: rtl/line_sensor_frontend.sv
// Charges, times and debounces three RC-decay reflectance sensors (left, middle, right).
// Macro LINE_SENSOR_DEBOUNCE_EN compiles in the consecutive-sample filter; without it raw bits pass straight through.

module line_sensor_frontend #(
   parameter int CHARGE_CYCLES  = 500,
   parameter int TIMEOUT_CYCLES = 150000,
   parameter int THRESHOLD      = 50000,
   parameter int FILTER_DEPTH   = 4,
   parameter int CNT_W          = 18
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sensor_in,
   output logic [2:0] sensor_oe,
   output logic [2:0] sensor_drive,
   output logic       sensorLeftFiltered,
   output logic       sensorMiddleFiltered,
   output logic       sensorRightFiltered,
   output logic       sample_valid
);

   localparam int CHG_W = (CHARGE_CYCLES > 1) ? $clog2(CHARGE_CYCLES) : 1;
   localparam logic [CHG_W-1:0] CHARGE_LAST  = CHG_W'(CHARGE_CYCLES - 1);
   localparam logic [CNT_W-1:0] MEASURE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_VAL  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] THRESH_VAL   = CNT_W'(THRESHOLD);

   typedef enum logic [1:0] {
      ST_CHARGE  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_UPDATE  = 2'd2
   } state_e;

   logic [2:0]            sync1_q;
   logic [2:0]            sync2_q;
   state_e                state_q, state_d;
   logic                  started_q;
   logic [CHG_W-1:0]      chargeCnt_q, chargeCnt_d;
   logic [CNT_W-1:0]      measCnt_q, measCnt_d;
   logic [2:0][CNT_W-1:0] decay_q, decay_d;
   logic [2:0]            latched_q, latched_d;
   logic [2:0]            rawBit;
   logic [2:0]            filt_q, filt_d;

   // Synchronizers idle high so a freshly reset block never sees a false decay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 3'b111;
         sync2_q <= 3'b111;
      end else begin
         sync1_q <= sensor_in;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_CHARGE;
         started_q   <= 1'b0;
         chargeCnt_q <= '0;
         measCnt_q   <= '0;
         decay_q     <= {3{TIMEOUT_VAL}};
         latched_q   <= '0;
      end else begin
         state_q     <= state_d;
         started_q   <= 1'b1;
         chargeCnt_q <= chargeCnt_d;
         measCnt_q   <= measCnt_d;
         decay_q     <= decay_d;
         latched_q   <= latched_d;
      end
   end

   // started_q holds off charging for the first cycle after reset so CHARGE is
   // always a full window with the pins released during reset.
   always_comb begin
      state_d     = state_q;
      chargeCnt_d = chargeCnt_q;
      measCnt_d   = measCnt_q;
      decay_d     = decay_q;
      latched_d   = latched_q;
      unique case (state_q)
         ST_CHARGE: begin
            measCnt_d = '0;
            latched_d = '0;
            decay_d   = {3{TIMEOUT_VAL}};
            if (started_q) begin
               if (chargeCnt_q == CHARGE_LAST) begin
                  chargeCnt_d = '0;
                  state_d     = ST_MEASURE;
               end else begin
                  chargeCnt_d = chargeCnt_q + 1'b1;
               end
            end
         end
         ST_MEASURE: begin
            for (int i = 0; i < 3; i++) begin
               if (!latched_q[i] && !sync2_q[i]) begin
                  decay_d[i]   = measCnt_q;
                  latched_d[i] = 1'b1;
               end
            end
            measCnt_d = measCnt_q + 1'b1;
            if ((&latched_d) || (measCnt_q == MEASURE_LAST)) begin
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            state_d = ST_CHARGE;
         end
         default: begin
            state_d = ST_CHARGE;
         end
      endcase
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         rawBit[i] = (decay_q[i] < THRESH_VAL);
      end
   end

`ifdef LINE_SENSOR_DEBOUNCE_EN
   localparam int FLT_W = $clog2(FILTER_DEPTH + 1);
   localparam logic [FLT_W-1:0] FLIP_AT = FLT_W'(FILTER_DEPTH - 1);

   logic [2:0][FLT_W-1:0] disCnt_q, disCnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disCnt_q <= '0;
      end else begin
         disCnt_q <= disCnt_d;
      end
   end

   // A run of FILTER_DEPTH disagreeing samples flips the output; any agreeing sample restarts the run.
   always_comb begin
      filt_d   = filt_q;
      disCnt_d = disCnt_q;
      if (state_q == ST_UPDATE) begin
         for (int i = 0; i < 3; i++) begin
            if (rawBit[i] == filt_q[i]) begin
               disCnt_d[i] = '0;
            end else if (disCnt_q[i] == FLIP_AT) begin
               filt_d[i]   = ~filt_q[i];
               disCnt_d[i] = '0;
            end else begin
               disCnt_d[i] = disCnt_q[i] + 1'b1;
            end
         end
      end
   end
`else
   always_comb begin
      filt_d = filt_q;
      if (state_q == ST_UPDATE) begin
         filt_d = rawBit;
      end
   end
`endif

   // Filtered bits reset to all-ones, which downstream treats as motors off.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q <= 3'b111;
      end else begin
         filt_q <= filt_d;
      end
   end

   always_comb begin
      sensor_oe    = 3'b000;
      sensor_drive = 3'b000;
      if ((state_q == ST_CHARGE) && started_q) begin
         sensor_oe    = 3'b111;
         sensor_drive = 3'b111;
      end
   end

   assign sample_valid         = (state_q == ST_UPDATE);
   assign sensorLeftFiltered   = filt_q[2];
   assign sensorMiddleFiltered = filt_q[1];
   assign sensorRightFiltered  = filt_q[0];

endmodule

// File: tb/tb_line_sensor_frontend.sv
// Directed bench for line_sensor_frontend (CHARGE=4, TIMEOUT=40, THRESHOLD=20, FILTER_DEPTH=3).
// Expected filtered values follow whether LINE_SENSOR_DEBOUNCE_EN is defined for the build.

module tb_line_sensor_frontend;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] sensor_in;
   logic [2:0] sensor_oe;
   logic [2:0] sensor_drive;
   logic       sensorLeftFiltered;
   logic       sensorMiddleFiltered;
   logic       sensorRightFiltered;
   logic       sample_valid;
   logic [2:0] filtOut;

   int assertCount = 0;
   int failCount   = 0;

`ifdef LINE_SENSOR_DEBOUNCE_EN
   localparam bit DEBOUNCE = 1'b1;
`else
   localparam bit DEBOUNCE = 1'b0;
`endif

   line_sensor_frontend #(
      .CHARGE_CYCLES (4),
      .TIMEOUT_CYCLES(40),
      .THRESHOLD     (20),
      .FILTER_DEPTH  (3),
      .CNT_W         (18)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .sensor_in           (sensor_in),
      .sensor_oe           (sensor_oe),
      .sensor_drive        (sensor_drive),
      .sensorLeftFiltered  (sensorLeftFiltered),
      .sensorMiddleFiltered(sensorMiddleFiltered),
      .sensorRightFiltered (sensorRightFiltered),
      .sample_valid        (sample_valid)
   );

   always #5 clk = ~clk;

   assign filtOut = {sensorLeftFiltered, sensorMiddleFiltered, sensorRightFiltered};

   // Runs one frame: pins pulled high for the charge, then each channel dropped at its
   // MEASURE offset (negative = never). A drop at offset d latches d+2 through the synchronizer.
   task automatic runFrame(input int dropL, input int dropM, input int dropR,
                           output int measLen, output logic [2:0] filtDuring,
                           output logic [2:0] filtAfter, output logic validAfter,
                           output logic [2:0] oeAfter);
      int guard;
      int k;
      int drops [3];
      drops[2]   = dropL;
      drops[1]   = dropM;
      drops[0]   = dropR;
      measLen    = -1;
      filtDuring = 3'bxxx;
      filtAfter  = 3'bxxx;
      validAfter = 1'bx;
      oeAfter    = 3'bxxx;
      sensor_in  = 3'b111;
      guard      = 0;
      while (sensor_oe !== 3'b111 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      while (sensor_oe !== 3'b000 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      k = 0;
      while (sample_valid !== 1'b1 && k < 100 && guard < 200) begin
         for (int i = 0; i < 3; i++) begin
            if (drops[i] == k) sensor_in[i] = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      if (sample_valid === 1'b1) begin
         measLen    = k;
         filtDuring = filtOut;
         @(negedge clk);
         filtAfter  = filtOut;
         validAfter = sample_valid;
         oeAfter    = sensor_oe;
      end
      sensor_in = 3'b111;
   endtask

   // Counts consecutive charge cycles from the current negedge; leaves the bench in MEASURE cycle 0.
   task automatic countCharge(output int chargeLen, output bit driveOk);
      int guard;
      chargeLen = 0;
      driveOk   = 1'b1;
      guard     = 0;
      while (guard < 30) begin
         @(negedge clk);
         guard++;
         if (sensor_drive !== sensor_oe) driveOk = 1'b0;
         if (sensor_oe === 3'b111) chargeLen++;
         else if (chargeLen > 0) break;
      end
   endtask

   task automatic test_reset();
      int chargeLen;
      bit driveOk;
      rst_n     = 1'b0;
      sensor_in = 3'b111;
      repeat (3) @(negedge clk);
      assertCount++;
      if (sensor_oe !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL reset_oe: got %b expected %b", sensor_oe, 3'b000);
      end
      assertCount++;
      if (sensor_drive !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL reset_drive: got %b expected %b", sensor_drive, 3'b000);
      end
      assertCount++;
      if (sample_valid !== 1'b0) begin
         failCount++;
         $display("[TB] FAIL reset_valid: got %b expected %b", sample_valid, 1'b0);
      end
      assertCount++;
      if (filtOut !== 3'b111) begin
         failCount++;
         $display("[TB] FAIL reset_filt: got %b expected %b", filtOut, 3'b111);
      end
      rst_n = 1'b1;
      countCharge(chargeLen, driveOk);
      assertCount++;
      if (chargeLen !== 4) begin
         failCount++;
         $display("[TB] FAIL reset_charge_len: got %0d expected %0d", chargeLen, 4);
      end
      assertCount++;
      if (driveOk !== 1'b1) begin
         failCount++;
         $display("[TB] FAIL reset_drive_follows_oe: got %b expected %b", driveOk, 1'b1);
      end
   endtask

   task automatic test_all_fast();
      int measLen;
      logic [2:0] fDur, fAft, oeAft;
      logic vAft;
      for (int f = 0; f < 3; f++) begin
         runFrame(5, 5, 5, measLen, fDur, fAft, vAft, oeAft);
         assertCount++;
         if (measLen !== 8) begin
            failCount++;
            $display("[TB] FAIL all_fast_len frame %0d: got %0d expected %0d", f, measLen, 8);
         end
         assertCount++;
         if (vAft !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL all_fast_valid_pulse frame %0d: got %b expected %b", f, vAft, 1'b0);
         end
         assertCount++;
         if (oeAft !== 3'b111) begin
            failCount++;
            $display("[TB] FAIL all_fast_recharge frame %0d: got %b expected %b", f, oeAft, 3'b111);
         end
         assertCount++;
         if (fAft !== 3'b111) begin
            failCount++;
            $display("[TB] FAIL all_fast_filt frame %0d: got %b expected %b", f, fAft, 3'b111);
         end
      end
   endtask

   task automatic test_middle_dark();
      int measLen;
      logic [2:0] fDur, fAft, oeAft, prevExp;
      logic vAft;
      logic [2:0] expAft [3];
      if (DEBOUNCE) expAft = '{3'b111, 3'b111, 3'b101};
      else          expAft = '{3'b101, 3'b101, 3'b101};
      prevExp = 3'b111;
      for (int f = 0; f < 3; f++) begin
         runFrame(5, -1, 5, measLen, fDur, fAft, vAft, oeAft);
         assertCount++;
         if (measLen !== 40) begin
            failCount++;
            $display("[TB] FAIL middle_dark_len frame %0d: got %0d expected %0d", f, measLen, 40);
         end
         assertCount++;
         if (fDur !== prevExp) begin
            failCount++;
            $display("[TB] FAIL middle_dark_filt_in_update frame %0d: got %b expected %b", f, fDur, prevExp);
         end
         assertCount++;
         if (fAft !== expAft[f]) begin
            failCount++;
            $display("[TB] FAIL middle_dark_filt frame %0d: got %b expected %b", f, fAft, expAft[f]);
         end
         prevExp = expAft[f];
      end
   endtask

   task automatic test_glitch();
      int measLen;
      int expLen;
      int dropM [9];
      logic [2:0] fDur, fAft, oeAft, prevExp;
      logic vAft;
      logic [2:0] expAft [9];
      dropM = '{5, 5, 5, -1, -1, 5, -1, -1, -1};
      if (DEBOUNCE)
         expAft = '{3'b101, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b101};
      else
         expAft = '{3'b111, 3'b111, 3'b111, 3'b101, 3'b101, 3'b111, 3'b101, 3'b101, 3'b101};
      prevExp = 3'b101;
      for (int f = 0; f < 9; f++) begin
         expLen = (dropM[f] < 0) ? 40 : 8;
         runFrame(5, dropM[f], 5, measLen, fDur, fAft, vAft, oeAft);
         assertCount++;
         if (measLen !== expLen) begin
            failCount++;
            $display("[TB] FAIL glitch_len frame %0d: got %0d expected %0d", f, measLen, expLen);
         end
         assertCount++;
         if (fDur !== prevExp) begin
            failCount++;
            $display("[TB] FAIL glitch_filt_in_update frame %0d: got %b expected %b", f, fDur, prevExp);
         end
         assertCount++;
         if (fAft !== expAft[f]) begin
            failCount++;
            $display("[TB] FAIL glitch_filt frame %0d: got %b expected %b", f, fAft, expAft[f]);
         end
         assertCount++;
         if (vAft !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL glitch_valid_pulse frame %0d: got %b expected %b", f, vAft, 1'b0);
         end
         prevExp = expAft[f];
      end
   endtask

   // Left drop at 17 latches 19 (below threshold), drop at 18 latches 20 (not below).
   task automatic test_threshold();
      int measLen;
      int dropL [6];
      logic [2:0] fDur, fAft, oeAft;
      logic vAft;
      logic [2:0] expAft [6];
      dropL = '{17, 17, 17, 18, 18, 18};
      if (DEBOUNCE) expAft = '{3'b101, 3'b101, 3'b101, 3'b101, 3'b101, 3'b001};
      else          expAft = '{3'b101, 3'b101, 3'b101, 3'b001, 3'b001, 3'b001};
      for (int f = 0; f < 6; f++) begin
         runFrame(dropL[f], -1, 5, measLen, fDur, fAft, vAft, oeAft);
         assertCount++;
         if (measLen !== 40) begin
            failCount++;
            $display("[TB] FAIL threshold_len frame %0d: got %0d expected %0d", f, measLen, 40);
         end
         assertCount++;
         if (fAft !== expAft[f]) begin
            failCount++;
            $display("[TB] FAIL threshold_filt frame %0d: got %b expected %b", f, fAft, expAft[f]);
         end
      end
   endtask

   task automatic test_reset_midframe();
      int guard;
      int chargeLen;
      bit driveOk;
      guard = 0;
      while (sensor_oe !== 3'b111 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      while (sensor_oe !== 3'b000 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      assertCount++;
      if (filtOut !== 3'b111) begin
         failCount++;
         $display("[TB] FAIL midmeasure_reset_filt: got %b expected %b", filtOut, 3'b111);
      end
      assertCount++;
      if (sensor_oe !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL midmeasure_reset_oe: got %b expected %b", sensor_oe, 3'b000);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      countCharge(chargeLen, driveOk);
      assertCount++;
      if (chargeLen !== 4) begin
         failCount++;
         $display("[TB] FAIL midmeasure_recharge_len: got %0d expected %0d", chargeLen, 4);
      end
      guard = 0;
      while (sensor_oe !== 3'b111 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      assertCount++;
      if (sensor_oe !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL midcharge_reset_oe: got %b expected %b", sensor_oe, 3'b000);
      end
      assertCount++;
      if (sensor_drive !== 3'b000) begin
         failCount++;
         $display("[TB] FAIL midcharge_reset_drive: got %b expected %b", sensor_drive, 3'b000);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      countCharge(chargeLen, driveOk);
      assertCount++;
      if (chargeLen !== 4) begin
         failCount++;
         $display("[TB] FAIL midcharge_recharge_len: got %0d expected %0d", chargeLen, 4);
      end
   endtask

   initial begin
      test_reset();
      test_all_fast();
      test_middle_dark();
      test_glitch();
      test_threshold();
      test_reset_midframe();
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1);
   end

endmodule
